// File: rtl/gb_pulse_generator.sv
// Game Boy style square-wave pulse channel: period timer, 8-step duty sequencer, length counter, sample gate.
// Latency: duty_step and channel_enable update on the edge after their cause; sample is registered one cycle behind duty_step.
// Backpressure: none; the channel free-runs on every clk cycle and never stalls its inputs.
//
// Ports: clk/reset (synchronous, active-high); trigger, frequency, sweep_overflow, duty, volume, dac_enable
// drive the channel; clk_length, length_load, length_data, length_enable drive the length counter;
// channel_enable, duty_step and sample are the outputs.
// Optional feature: define GB_PULSE_LENGTH_EN to build the length counter; otherwise its inputs are ignored.
module gb_pulse_generator (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [10:0] frequency,
    input  logic        sweep_overflow,
    input  logic [1:0]  duty,
    input  logic [3:0]  volume,
    input  logic        dac_enable,
    input  logic        clk_length,
    input  logic        length_load,
    input  logic [5:0]  length_data,
    input  logic        length_enable,
    output logic        channel_enable,
    output logic [2:0]  duty_step,
    output logic [3:0]  sample
);

    localparam logic [11:0] PERIOD_MAX = 12'd2048;

    logic [11:0] timer_q, timer_d;
    logic [2:0]  duty_step_q, duty_step_d;
    logic        channel_enable_q, channel_enable_d;
    logic [3:0]  sample_q, sample_d;

    logic [11:0] reload_val;
    logic        step_high;
    logic        length_expire;

    // frequency is only sampled here, and reload_val is only used at a reload or trigger,
    // so a frequency change never shortens or stretches the period already in progress.
    assign reload_val = PERIOD_MAX - {1'b0, frequency};

    always_comb begin
        step_high = 1'b0;
        case (duty)
            2'd0:    step_high = (duty_step_q == 3'd7);
            2'd1:    step_high = (duty_step_q == 3'd0) || (duty_step_q == 3'd7);
            2'd2:    step_high = (duty_step_q == 3'd0) || (duty_step_q >= 3'd5);
            default: step_high = (duty_step_q != 3'd0) && (duty_step_q != 3'd7);
        endcase
    end

`ifdef GB_PULSE_LENGTH_EN
    logic [6:0] length_q, length_d;

    // Priority: an explicit load beats everything; a trigger only refills an
    // exhausted counter and suppresses the tick of that cycle.
    always_comb begin
        length_d      = length_q;
        length_expire = 1'b0;
        if (length_load) begin
            length_d = 7'd64 - {1'b0, length_data};
        end else if (trigger) begin
            if (length_q == 7'd0) begin
                length_d = 7'd64;
            end
        end else if (clk_length && length_enable && (length_q != 7'd0)) begin
            length_d      = length_q - 7'd1;
            length_expire = (length_q == 7'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            length_q <= 7'd0;
        end else begin
            length_q <= length_d;
        end
    end
`else
    logic unused_length_inputs;
    assign unused_length_inputs = ^{clk_length, length_load, length_data, length_enable};
    assign length_expire        = 1'b0;
`endif

    always_comb begin
        timer_d          = timer_q;
        duty_step_d      = duty_step_q;
        channel_enable_d = channel_enable_q;

        if (channel_enable_q) begin
            if (timer_q == 12'd1) begin
                timer_d     = reload_val;
                duty_step_d = duty_step_q + 3'd1;
            end else begin
                timer_d = timer_q - 12'd1;
            end
        end

        // Trigger restarts the period but deliberately keeps the waveform phase.
        if (trigger) begin
            timer_d = reload_val;
            if (dac_enable) begin
                channel_enable_d = 1'b1;
            end
        end

        // Clear conditions are applied last so they win over a simultaneous trigger.
        if (sweep_overflow || !dac_enable || length_expire) begin
            channel_enable_d = 1'b0;
        end

        // Gate with the next enable so the sample drops on the same edge the channel shuts off.
        sample_d = (channel_enable_d && dac_enable && step_high) ? volume : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q          <= PERIOD_MAX;
            duty_step_q      <= 3'd0;
            channel_enable_q <= 1'b0;
            sample_q         <= 4'h0;
        end else begin
            timer_q          <= timer_d;
            duty_step_q      <= duty_step_d;
            channel_enable_q <= channel_enable_d;
            sample_q         <= sample_d;
        end
    end

    assign channel_enable = channel_enable_q;
    assign duty_step      = duty_step_q;
    assign sample         = sample_q;

endmodule

// File: tb/tb_gb_pulse_generator.sv
module tb_gb_pulse_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger;
    logic [10:0] frequency;
    logic        sweep_overflow;
    logic [1:0]  duty;
    logic [3:0]  volume;
    logic        dac_enable;
    logic        clk_length;
    logic        length_load;
    logic [5:0]  length_data;
    logic        length_enable;
    logic        channel_enable;
    logic [2:0]  duty_step;
    logic [3:0]  sample;

`ifdef GB_PULSE_LENGTH_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    gb_pulse_generator dut (
        .clk            (clk),
        .reset          (reset),
        .trigger        (trigger),
        .frequency      (frequency),
        .sweep_overflow (sweep_overflow),
        .duty           (duty),
        .volume         (volume),
        .dac_enable     (dac_enable),
        .clk_length     (clk_length),
        .length_load    (length_load),
        .length_data    (length_data),
        .length_enable  (length_enable),
        .channel_enable (channel_enable),
        .duty_step      (duty_step),
        .sample         (sample)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        trigger        = 1'b0;
        frequency      = 11'd0;
        sweep_overflow = 1'b0;
        duty           = 2'd0;
        volume         = 4'd0;
        dac_enable     = 1'b0;
        clk_length     = 1'b0;
        length_load    = 1'b0;
        length_data    = 6'd0;
        length_enable  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Duty waveform tables written out by hand: bit i set means step i is high.
    function automatic bit is_high(input logic [1:0] d, input int s);
        logic [7:0] m;
        case (d)
            2'd0:    m = 8'b1000_0000;
            2'd1:    m = 8'b1000_0001;
            2'd2:    m = 8'b1110_0001;
            default: m = 8'b0111_1110;
        endcase
        return m[s];
    endfunction

    initial begin
        int prev;
        int exp_step;

        // Reset values
        do_reset();
        check("rst_en", channel_enable, 0);
        check("rst_step", duty_step, 0);
        check("rst_sample", sample, 0);

        // duty 2, period 4 cycles
        dac_enable = 1'b1;
        duty       = 2'd2;
        volume     = 4'd15;
        frequency  = 11'd2044;
        trigger    = 1'b1;
        tick();
        trigger = 1'b0;
        check("p4_en", channel_enable, 1);
        for (int k = 0; k < 36; k++) begin
            if (k != 0) tick();
            exp_step = (k / 4) % 8;
            prev     = (k == 0) ? 0 : ((k - 1) / 4) % 8;
            check("p4_step", duty_step, exp_step);
            check("p4_sample", sample, is_high(2'd2, prev) ? 15 : 0);
        end

        // duty 3, period 1 cycle
        do_reset();
        dac_enable = 1'b1;
        duty       = 2'd3;
        volume     = 4'd15;
        frequency  = 11'd2047;
        trigger    = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k != 0) tick();
            prev = (k == 0) ? 0 : (k - 1) % 8;
            check("p1_step", duty_step, k % 8);
            check("p1_sample", sample, is_high(2'd3, prev) ? 15 : 0);
        end

        // Mid-period frequency change: 8-cycle period completes, then 2-cycle periods
        do_reset();
        dac_enable = 1'b1;
        volume     = 4'd15;
        frequency  = 11'd2040;
        trigger    = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) frequency = 11'd2046;
            exp_step = (k < 8) ? 0 : (k < 10) ? 1 : (k < 12) ? 2 : 3;
            check("fchg_step", duty_step, exp_step);
        end

        // Sweep overflow and DAC disable
        do_reset();
        dac_enable     = 1'b1;
        duty           = 2'd3;
        volume         = 4'd9;
        frequency      = 11'd2047;
        trigger        = 1'b1;
        sweep_overflow = 1'b1;
        tick();
        trigger        = 1'b0;
        sweep_overflow = 1'b0;
        check("ovf_trig_en", channel_enable, 0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("ovf_start_en", channel_enable, 1);
        tick();
        tick();
        tick();
        check("ovf_pre_step", duty_step, 3);
        check("ovf_pre_sample", sample, 9);
        sweep_overflow = 1'b1;
        tick();
        sweep_overflow = 1'b0;
        check("ovf_en", channel_enable, 0);
        check("ovf_sample", sample, 0);
        check("ovf_step", duty_step, 4);
        tick();
        check("hold_step", duty_step, 4);
        check("hold_sample", sample, 0);
        dac_enable = 1'b0;
        trigger    = 1'b1;
        tick();
        trigger = 1'b0;
        check("dacoff_trig_en", channel_enable, 0);
        dac_enable = 1'b1;
        trigger    = 1'b1;
        tick();
        trigger = 1'b0;
        check("dacon_trig_en", channel_enable, 1);
        dac_enable = 1'b0;
        tick();
        check("dacoff_en", channel_enable, 0);
        check("dacoff_sample", sample, 0);

        // Length counter
        do_reset();
        dac_enable    = 1'b1;
        frequency     = 11'd2047;
        length_data   = 6'd62;
        length_load   = 1'b1;
        tick();
        length_load   = 1'b0;
        length_enable = 1'b1;
        trigger       = 1'b1;
        tick();
        trigger = 1'b0;
        check("len_start_en", channel_enable, 1);
        clk_length = 1'b1;
        tick();
        clk_length = 1'b0;
        check("len_tick1_en", channel_enable, 1);
        clk_length = 1'b1;
        tick();
        clk_length = 1'b0;
        check("len_tick2_en", channel_enable, LEN_EN ? 0 : 1);
        // trigger on empty counter refills to 64; same-cycle tick is dropped
        trigger    = 1'b1;
        clk_length = 1'b1;
        tick();
        trigger = 1'b0;
        check("len_refill_en", channel_enable, 1);
        for (int k = 0; k < 63; k++) tick();
        check("len_63_en", channel_enable, 1);
        tick();
        clk_length = 1'b0;
        check("len_64_en", channel_enable, LEN_EN ? 0 : 1);
        // load beats a same-cycle tick
        length_data = 6'd63;
        length_load = 1'b1;
        clk_length  = 1'b1;
        tick();
        length_load = 1'b0;
        clk_length  = 1'b0;
        trigger     = 1'b1;
        tick();
        trigger = 1'b0;
        check("len_ld_en", channel_enable, 1);
        clk_length = 1'b1;
        tick();
        clk_length = 1'b0;
        check("len_ld_exp_en", channel_enable, LEN_EN ? 0 : 1);

        // Reset mid-period overrides trigger, load and ticks
        do_reset();
        dac_enable = 1'b1;
        duty       = 2'd1;
        volume     = 4'd7;
        frequency  = 11'd2047;
        trigger    = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("mid_step", duty_step, 5);
        reset       = 1'b1;
        trigger     = 1'b1;
        length_load = 1'b1;
        clk_length  = 1'b1;
        tick();
        check("mrst_en", channel_enable, 0);
        check("mrst_step", duty_step, 0);
        check("mrst_sample", sample, 0);
        reset       = 1'b0;
        trigger     = 1'b0;
        length_load = 1'b0;
        clk_length  = 1'b0;
        tick();
        check("post_rst_en", channel_enable, 0);
        check("post_rst_step", duty_step, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_pulse_generator.md
GB_PULSE_GENERATOR -- requirements
Module: gb_pulse_generator

Interface
REQ-001 SHALL have ports (name direction width meaning):
- clk  input  1  system clock, one timer tick per cycle
- reset  input  1  synchronous, active-high
- trigger  input  1  one-cycle channel trigger pulse (NRx4 bit 7)
- frequency  input  11  period value from the sweep stage's shadow_frequency
- sweep_overflow  input  1  overflow flag from the sweep stage
- duty  input  2  duty select (NRx1[7:6])
- volume  input  4  current envelope volume
- dac_enable  input  1  DAC power (NRx2[7:3] nonzero)
- clk_length  input  1  one-cycle 256 Hz length tick
- length_load  input  1  one-cycle length write strobe
- length_data  input  6  NRx1[5:0]
- length_enable  input  1  NRx4 bit 6
- channel_enable  output  1  channel active (NR52 status bit)
- duty_step  output  3  current waveform step
- sample  output  4  digital sample to the DAC
REQ-002 SHALL use a single clock domain, clk; reset is synchronous and active-high.

Function
REQ-003 Period timer: 12-bit down-counter; reload value = 2048 - frequency (range 1..2048).
REQ-004 While channel_enable=1: timer==1 -> reload and duty_step += 1 mod 8 on that edge; else timer -= 1.
REQ-005 While channel_enable=0: timer and duty_step hold.
REQ-006 A frequency change SHALL take effect only at the next reload or trigger, never mid-period.
REQ-007 frequency=2047 -> duty_step advances every cycle; frequency=0 -> every 2048 cycles.
REQ-008 Trigger: timer loaded with 2048 - frequency on the same edge; duty_step NOT reset by trigger.
REQ-009 Duty high steps: duty=0 -> {7}; 1 -> {0,7}; 2 -> {0,5,6,7}; 3 -> {1..6}.
REQ-010 sample = volume when channel_enable=1, dac_enable=1 and current step high; else 4'h0; registered, 1-cycle latency from duty_step.
REQ-011 channel_enable set on trigger edge iff dac_enable=1.
REQ-012 channel_enable cleared on the edge where any of: sweep_overflow=1, dac_enable=0, length expiry.
REQ-013 Simultaneous trigger and sweep_overflow: clear wins (channel_enable=0); timer still reloaded.
REQ-014 Length counter (7-bit, 0..64): length_load -> counter = 64 - length_data.
REQ-015 clk_length with length_enable=1 and counter!=0 -> decrement; transition to 0 clears channel_enable.
REQ-016 Trigger with length counter==0 -> counter = 64.
REQ-017 Simultaneous length_load and clk_length: load wins, no decrement that cycle.
REQ-018 Simultaneous trigger and clk_length: trigger reload (if applicable) first, no decrement that cycle.

Reset
REQ-019 Reset: channel_enable=0, duty_step=0, sample=0, timer=2048, length counter=0.
REQ-020 Reset asserted mid-period SHALL override trigger, length_load and all ticks on that edge.

Configuration
REQ-021 Macro GB_PULSE_LENGTH_EN defined: length counter per REQ-014..018 compiled in.
REQ-022 Macro absent: no length counter; clk_length, length_load, length_data, length_enable ignored; channel cleared only by sweep_overflow or dac_enable=0; port list unchanged.

Verification
REQ-023 reset; dac_enable=1, duty=2, volume=15, frequency=2044, trigger -> duty_step increments every 4 cycles; sample=15 at steps 0,5,6,7, else 0.
REQ-024 frequency=2047, duty=3, trigger -> duty_step increments every cycle; sample high for steps 1..6 only.
REQ-025 Running at frequency=2040, change frequency to 2046 mid-period -> current period completes at 8 cycles, next period 2 cycles.
REQ-026 Trigger with sweep_overflow=1 same cycle -> channel_enable stays 0; sweep_overflow later while active -> channel_enable=0 next edge, sample=0.
REQ-027 (GB_PULSE_LENGTH_EN) length_data=62, length_enable=1, trigger, 2 clk_length pulses -> channel_enable=0 after 2nd; without macro channel_enable stays 1.
REQ-028 Assert reset while active at duty_step=5 -> all outputs at reset values next edge.
